line_rasterizer: RTL
====================

Name: line_rasterizer

Overview:
- Bresenham line rasterizer.
- Sits directly downstream of the triangle edge sequencer: it accepts one edge (x0,y0)->(x1,y1) per Start/Done handshake and emits one pixel coordinate per accepted cycle toward the framebuffer write stage.
- Covers all octants, includes both endpoints, and supports backpressure from the pixel consumer.

Parameters:
- COORD_W, 10, coordinate width in bits (unsigned screen coordinates, 0..1023).

Ports:
- Clk  input  1  system clock; all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  level request; coordinates sampled in IDLE when high
- x0  input  COORD_W  start point X
- y0  input  COORD_W  start point Y
- x1  input  COORD_W  end point X
- y1  input  COORD_W  end point Y
- DrawX  output  COORD_W  current pixel X
- DrawY  output  COORD_W  current pixel Y
- Pixel_Valid  output  1  DrawX/DrawY hold a pixel to be written
- Pixel_Ready  input  1  consumer accepts the pixel this cycle when high with Pixel_Valid
- Busy  output  1  high in SETUP or PLOT
- Done  output  1  high in DONE state

Behaviour:
- Reset (synchronous, wins over everything): state=IDLE; DrawX=0, DrawY=0, Pixel_Valid=0, Busy=0, Done=0. Internal dx, dy, err, sx, sy cleared. Reset mid-line abandons the line; no further pixels are emitted.
- States: IDLE, SETUP, PLOT, DONE.
- IDLE:
  - If Start=1, latch x0,y0,x1,y1 into internal registers and go to SETUP.
  - Coordinate changes after latch are ignored until the next IDLE.
- SETUP (1 cycle):
  - dx = |x1-x0| and dy = -|y1-y0|, as signed COORD_W+2 bits.
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1.
  - err = dx+dy, as signed COORD_W+2 bits.
  - Current point = (x0,y0). Pixel_Valid rises entering PLOT.
- PLOT:
  - Pixel_Valid=1, with DrawX/DrawY = current point.
  - On Pixel_Valid & Pixel_Ready:
    - If current == (x1,y1), go to DONE and drop Pixel_Valid.
    - Else, with e2 = 2*err:
      - if e2 >= dy: err += dy, X += sx;
      - if e2 <= dx: err += dx, Y += sy.
      - Both updates use the same pre-update err in one cycle.
  - When Pixel_Ready=0, the point, err and outputs hold unchanged.
  - No pixel is ever skipped or duplicated.
- DONE: Done=1, Busy=0, Pixel_Valid=0. Return to IDLE when Start=0.
- Throughput and latency:
  - One pixel per cycle under full Ready.
  - The first pixel is valid 2 cycles after the Start edge is sampled in IDLE.
  - Pixel count = max(|x1-x0|, |y1-y0|) + 1, endpoints inclusive.
- Degenerate input: x0==x1 and y0==y1 emits exactly one pixel, then DONE.
- Arithmetic: coordinates never leave the bounding box of the endpoints, so no wrap-around is possible. Internal signed width prevents err overflow for 1023-length lines.
- Start held high through DONE does not retrigger; the requester must drop Start to see IDLE.

Test Plan:
- Horizontal: Start with (20,20)->(40,20), Ready=1 -> 21 pixels, X=20..40 step +1, Y=20 constant; Done after last pixel; first Pixel_Valid 2 cycles after Start sampled.
- Steep reverse edge: (40,20)->(30,50) -> 31 pixels, Y=20..50 monotonic +1, X non-increasing 40..30, last pixel (30,50) exact; repeat with (30,50)->(20,20) -> 31 pixels ending at (20,20).
- Single point and diagonal: (5,5)->(5,5) -> exactly 1 pixel (5,5); (0,0)->(7,7) -> 8 pixels, each (i,i).
- Backpressure: (20,20)->(40,20) with Pixel_Ready toggled 1,0,0,1 pattern -> DrawX/DrawY stable while Ready=0; exactly 21 distinct accepted pixels in order; no duplicates at the consumer.
- Reset mid-line: assert Reset after 5 accepted pixels -> next cycle Pixel_Valid=0, Busy=0, Done=0, DrawX=DrawY=0; new Start (0,0)->(3,0) then yields 4 pixels correctly.
- Handshake: Start held high after Done -> Done stays 1, no new pixels; Start=0 -> IDLE next cycle, Done=0.

Source files
------------

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line rasterizer covering all octants.
// Accepts one edge (x0,y0)->(x1,y1) per Start/Done handshake and emits one
// pixel per accepted Pixel_Valid/Pixel_Ready cycle, both endpoints included.
module line_rasterizer #(
  parameter int COORD_W = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               Pixel_Valid,
  input  logic               Pixel_Ready,
  output logic               Busy,
  output logic               Done
);

  // Two extra bits: one for sign, one so dx+dy and err updates of a
  // full-screen line cannot overflow.
  localparam int SW = COORD_W + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PLOT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  logic [1:0]                state_q, state_d;
  logic [COORD_W-1:0]        lx0_q, ly0_q, lx1_q, ly1_q;
  logic [COORD_W-1:0]        lx0_d, ly0_d, lx1_d, ly1_d;
  logic [COORD_W-1:0]        cur_x_q, cur_y_q, cur_x_d, cur_y_d;
  logic signed [SW-1:0]      dx_q, dy_q, err_q, dx_d, dy_d, err_d;
  // Step direction flags: 1 means step by -1, 0 means step by +1.
  logic                      sx_q, sy_q, sx_d, sy_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [COORD_W-1:0]        abs_dx_s, abs_dy_s;
  logic signed [SW-1:0]      setup_dx_s, setup_dy_s;
  logic signed [SW:0]        e2_s, dx_ext_s, dy_ext_s;
  logic                      step_x_s, step_y_s;
  logic signed [SW-1:0]      err_add_x_s, err_add_y_s;
  logic                      at_end_s, accept_s;

  assign DrawX       = cur_x_q;
  assign DrawY       = cur_y_q;
  assign Pixel_Valid = valid_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

  // Setup-time geometry and per-pixel Bresenham step decisions.
  always_comb begin
    abs_dx_s    = (lx1_q >= lx0_q) ? (lx1_q - lx0_q) : (lx0_q - lx1_q);
    abs_dy_s    = (ly1_q >= ly0_q) ? (ly1_q - ly0_q) : (ly0_q - ly1_q);
    setup_dx_s  = signed'({2'b00, abs_dx_s});
    setup_dy_s  = {SW{1'b0}} - signed'({2'b00, abs_dy_s});
    e2_s        = {err_q, 1'b0};
    dx_ext_s    = {dx_q[SW-1], dx_q};
    dy_ext_s    = {dy_q[SW-1], dy_q};
    step_x_s    = (e2_s >= dy_ext_s);
    step_y_s    = (e2_s <= dx_ext_s);
    err_add_x_s = step_x_s ? dy_q : {SW{1'b0}};
    err_add_y_s = step_y_s ? dx_q : {SW{1'b0}};
    at_end_s    = (cur_x_q == lx1_q) && (cur_y_q == ly1_q);
    accept_s    = valid_q && Pixel_Ready;
  end

  // Next-state logic for the control FSM and the datapath registers.
  always_comb begin
    state_d = state_q;
    lx0_d   = lx0_q;
    ly0_d   = ly0_q;
    lx1_d   = lx1_q;
    ly1_d   = ly1_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          lx0_d   = x0;
          ly0_d   = y0;
          lx1_d   = x1;
          ly1_d   = y1;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_SETUP: begin
        dx_d    = setup_dx_s;
        dy_d    = setup_dy_s;
        err_d   = setup_dx_s + setup_dy_s;
        sx_d    = !(lx0_q < lx1_q);
        sy_d    = !(ly0_q < ly1_q);
        cur_x_d = lx0_q;
        cur_y_d = ly0_q;
        valid_d = 1'b1;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        if (accept_s) begin
          if (at_end_s) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // Both axis updates use the same pre-update err.
            err_d = err_q + err_add_x_s + err_add_y_s;
            if (step_x_s) begin
              cur_x_d = sx_q ? (cur_x_q - ONE) : (cur_x_q + ONE);
            end else begin
              cur_x_d = cur_x_q;
            end
            if (step_y_s) begin
              cur_y_d = sy_q ? (cur_y_q - ONE) : (cur_y_q + ONE);
            end else begin
              cur_y_d = cur_y_q;
            end
          end
        end else begin
          state_d = S_PLOT;
        end
      end
      S_DONE: begin
        // A held Start must not retrigger; wait for it to drop.
        if (!Start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      lx0_q   <= {COORD_W{1'b0}};
      ly0_q   <= {COORD_W{1'b0}};
      lx1_q   <= {COORD_W{1'b0}};
      ly1_q   <= {COORD_W{1'b0}};
      cur_x_q <= {COORD_W{1'b0}};
      cur_y_q <= {COORD_W{1'b0}};
      dx_q    <= {SW{1'b0}};
      dy_q    <= {SW{1'b0}};
      err_q   <= {SW{1'b0}};
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lx0_q   <= lx0_d;
      ly0_q   <= ly0_d;
      lx1_q   <= lx1_d;
      ly1_q   <= ly1_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
